// File: rtl/weight_streamer.sv
// rtl/weight_streamer.sv - LOAD/READ initiator for the SNN synchronous weight memory.
// Optional SNN_WS_CHECKSUM_EN adds an XOR checksum output (csum) over all handshaked words.
module weight_streamer #(
  parameter int ADDR_W = 2,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
`ifdef SNN_WS_CHECKSUM_EN
  output logic [DW-1:0]     csum,
`endif
  input  logic [DW-1:0]     mem_rdata
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W:0] N_CNT    = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] LAST_CNT = N_CNT - 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   wcnt, rptr, ocnt;
  logic              inflight;
  logic [DW-1:0]     fifo0, fifo1;
  logic              wr_sel, rd_sel;
  logic [1:0]        fcount;
  logic [2:0]        occ;
  logic              start_acc, in_hs, out_hs, issue;

  assign start_acc = (state == S_IDLE) && start;
  assign in_hs     = (state == S_LOAD) && in_valid;
  assign out_hs    = out_valid && out_ready;
  assign occ       = {1'b0, fcount} + {2'b00, inflight};
  // A pop in the same cycle frees a slot, which keeps READ at one word per cycle.
  assign issue     = (state == S_READ) && (rptr < N_CNT) && ((occ < 3'd2) || out_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = mode ? S_LOAD : S_READ;
      S_LOAD: if (in_hs && (wcnt == LAST_CNT)) state_nxt = S_FIN;
      S_READ: if (out_hs && out_last) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_FIN);
    in_ready  = (state == S_LOAD);
    mem_we    = in_hs;
    mem_wdata = in_hs ? in_data : '0;
    mem_addr  = '0;
    if (state == S_LOAD)      mem_addr = wcnt[ADDR_W-1:0];
    else if (state == S_READ) mem_addr = rptr[ADDR_W-1:0];
    out_valid = (state == S_READ) && (fcount != 2'd0);
    out_data  = rd_sel ? fifo1 : fifo0;
    out_last  = out_valid && (ocnt == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      rptr     <= '0;
      ocnt     <= '0;
      inflight <= 1'b0;
      fifo0    <= '0;
      fifo1    <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      fcount   <= 2'd0;
    end else if (start_acc) begin
      wcnt     <= '0;
      rptr     <= '0;
      ocnt     <= '0;
      inflight <= 1'b0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      fcount   <= 2'd0;
    end else begin
      if (in_hs) wcnt <= wcnt + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      inflight <= issue;
      // Memory data for last cycle's address is valid now; capture it.
      if (inflight) begin
        if (wr_sel) fifo1 <= mem_rdata;
        else        fifo0 <= mem_rdata;
        wr_sel <= ~wr_sel;
      end
      if (out_hs) begin
        rd_sel <= ~rd_sel;
        ocnt   <= ocnt + 1'b1;
      end
      fcount <= fcount + {1'b0, inflight} - {1'b0, out_hs};
    end
  end

`ifdef SNN_WS_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         csum <= '0;
    else if (start_acc) csum <= '0;
    else if (in_hs)     csum <= csum ^ in_data;
    else if (out_hs)    csum <= csum ^ out_data;
  end
`endif

endmodule

// File: tb/tb_weight_streamer.sv
// tb/tb_weight_streamer.sv - scoreboard bench for weight_streamer with a synchronous memory model.
module tb_weight_streamer;
  localparam int ADDR_W = 2;
  localparam int DW     = 8;
  localparam int N      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic busy, done, in_ready, out_valid, out_last, mem_we;
  logic [DW-1:0] out_data, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
`ifdef SNN_WS_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  logic [DW-1:0] mem [N];
  logic [DW-1:0] shadow [N];
  logic [DW-1:0] exp_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_streamer #(.ADDR_W(ADDR_W), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef SNN_WS_CHECKSUM_EN
    .csum(csum),
`endif
    .mem_rdata(mem_rdata)
  );

  // Read-before-write synchronous memory.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if ({busy, done, in_ready, out_valid, out_last, mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000000", {busy, done, in_ready, out_valid, out_last, mem_we});
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus got addr=%0h wdata=%0h want 0/0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_load(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                          input bit gaps, input bit spam, input int abort_after);
    logic [DW-1:0] words [N];
    logic [DW-1:0] ed;
    logic [ADDR_W-1:0] ea;
    int idx, last_wr, first_wr;
    bit fin;
`ifdef SNN_WS_CHECKSUM_EN
    logic [DW-1:0] x;
    x = '0;
`endif
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(words[i]);
      exp_addr_q.push_back(ADDR_W'(i));
`ifdef SNN_WS_CHECKSUM_EN
      x ^= words[i];
`endif
    end
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    idx = 0; fin = 1'b0; last_wr = -10; first_wr = -1;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clk);
      in_valid = (idx < N) && (!gaps || $urandom_range(0, 2) != 0);
      in_data  = in_valid ? words[idx] : DW'($urandom);
      start    = spam;
      mode     = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        ed = exp_q.pop_front();
        ea = exp_addr_q.pop_front();
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== ea || mem_wdata !== ed) begin
          errors++;
          $display("FAIL load_write got we=%b addr=%0d data=%0h want we=1 addr=%0d data=%0h",
                   mem_we, mem_addr, mem_wdata, ea, ed);
        end
        shadow[idx] = in_data;
        idx++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (idx == abort_after) begin
          @(negedge clk);
          in_valid = 1'b0; start = 1'b0; rst_n = 1'b0;
          #1;
          vectors++;
          if ({busy, done, in_ready, mem_we} !== 4'b0) begin
            errors++;
            $display("FAIL abort_reset got busy/done/in_ready/we=%b want 0000", {busy, done, in_ready, mem_we});
          end
          @(negedge clk);
          #1;
          vectors++;
          if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got done=%b want 0", done);
          end
          rst_n = 1'b1;
          return;
        end
      end else begin
        vectors++;
        if (mem_we !== 1'b0) begin
          errors++;
          $display("FAIL load_idle_we got we=%b want 0", mem_we);
        end
      end
      if (done) begin
        fin = 1'b1;
        vectors++;
        if (cyc !== last_wr + 1 || idx !== N) begin
          errors++;
          $display("FAIL load_done_timing got cyc=%0d words=%0d want cyc=%0d words=%0d", cyc, idx, last_wr + 1, N);
        end
        if (!gaps) begin
          vectors++;
          if (last_wr - first_wr !== N - 1) begin
            errors++;
            $display("FAIL load_consecutive got span=%0d want %0d", last_wr - first_wr, N - 1);
          end
        end
`ifdef SNN_WS_CHECKSUM_EN
        vectors++;
        if (csum !== x) begin
          errors++;
          $display("FAIL load_csum got=%0h want=%0h", csum, x);
        end
`endif
      end
    end
    if (!fin) begin
      vectors++; errors++;
      $display("FAIL load_timeout got words=%0d want %0d", idx, N);
    end
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_fin got busy=%b want 0", busy);
    end
  endtask

  // pattern: 0 = always ready, 1 = 1,0,0,1,0,1 repeating, 2 = random
  task automatic run_read(input int pattern);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [DW-1:0] e, held_data;
    logic held_last;
    bit held, fin;
    int first_v, first_hs, last_hs, got;
`ifdef SNN_WS_CHECKSUM_EN
    logic [DW-1:0] x;
    x = '0;
`endif
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(shadow[i]);
`ifdef SNN_WS_CHECKSUM_EN
      x ^= shadow[i];
`endif
    end
    @(negedge clk);
    start = 1'b1; mode = 1'b0; out_ready = 1'b0;
    held = 1'b0; fin = 1'b0; first_v = -1; first_hs = -1; last_hs = -10; got = 0;
    held_data = '0; held_last = 1'b0;
    for (int cyc = 1; cyc < 80 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = (pattern == 0) ? 1'b1 : (pattern == 1) ? pat[cyc % 6] : 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL read_we got=%b want 0", mem_we);
      end
      // cyc 1 follows the edge that sampled start, so 2 cycles of latency lands on cyc 3.
      if (out_valid && first_v < 0) begin
        first_v = cyc;
        vectors++;
        if (cyc !== 3) begin
          errors++;
          $display("FAIL read_latency got cyc=%0d want 3", cyc);
        end
      end
      if (held) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
          errors++;
          $display("FAIL read_stall_hold got v=%b d=%0h l=%b want v=1 d=%0h l=%b",
                   out_valid, out_data, out_last, held_data, held_last);
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_extra got d=%0h want no word", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e || out_last !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL read_word got d=%0h l=%b want d=%0h l=%b", out_data, out_last, e, exp_q.size() == 0);
          end
        end
        got++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (done) begin
        fin = 1'b1;
        vectors++;
        if (cyc !== last_hs + 1 || got !== N) begin
          errors++;
          $display("FAIL read_done got cyc=%0d words=%0d want cyc=%0d words=%0d", cyc, got, last_hs + 1, N);
        end
        if (pattern == 0) begin
          vectors++;
          if (last_hs - first_hs !== N - 1) begin
            errors++;
            $display("FAIL read_throughput got span=%0d want %0d", last_hs - first_hs, N - 1);
          end
        end
`ifdef SNN_WS_CHECKSUM_EN
        vectors++;
        if (csum !== x) begin
          errors++;
          $display("FAIL read_csum got=%0h want=%0h", csum, x);
        end
`endif
      end
    end
    if (!fin) begin
      vectors++; errors++;
      $display("FAIL read_timeout got words=%0d want %0d", got, N);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_load_stream;
    run_load(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, N + 1);
  endtask

  task automatic test_read_stream;
    run_read(0);
  endtask

  task automatic test_read_backpressure;
    run_read(1);
  endtask

  task automatic test_load_gaps_spam;
    run_load(8'h5A, 8'hA5, 8'h3C, 8'hC3, 1'b1, 1'b1, N + 1);
    run_read(2);
  endtask

  task automatic test_reset_abort;
    run_load(8'hE1, 8'hE2, 8'hE3, 8'hE4, 1'b0, 1'b0, 2);
    run_read(0);
  endtask

  initial begin
    test_reset;
    test_load_stream;
    test_read_stream;
    test_read_backpressure;
    test_load_gaps_spam;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
